// File: rtl/expansion_shiftreg_chain_pkg.sv
// Shared definitions for the expansion shift-register chain driver:
// frame state encoding and the frame counter width.
`timescale 1ns/1ps

package expansion_shiftreg_chain_pkg;

    // Width of the completed-frame counter exposed on the top level.
    localparam int FRAME_CNT_W = 16;

    // Frame sequencing states; every transition happens on a shift tick.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        SHIFT_LO = 2'd2,
        SHIFT_HI = 2'd3
    } chain_state_t;

endpackage

// File: rtl/expansion_shiftreg_chain_tick_gen.sv
// Free-running clock divider producing a one-clk tick every DIVIDER clocks.
// Shared by the expansion blocks so their pin timing stays consistent.
`timescale 1ns/1ps

module expansion_tick_gen #(
    parameter int DIVIDER = 251
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDER - 1);

    logic [CNT_W-1:0] cnt;

    // Count 0..DIVIDER-1 and wrap; never stalls so tick spacing is fixed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/expansion_shiftreg_chain.sv
// Multi-channel 74HC595/74HC165 chain driver. All chains share SHIFT_CLK and
// SHIFT_LOAD; each channel has its own serial out/in pin. A frame is one LOAD
// tick followed by WIDTH low/high shift clock pairs, MSB first in both
// directions. Outputs reach the 595 pins one frame late because the latch edge
// is the rising SHIFT_LOAD at the start of the following frame.
`timescale 1ns/1ps

module expansion_shiftreg_chain
    import expansion_shiftreg_chain_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 1,
    parameter int DIVIDER  = 251,
    parameter int ONCHANGE = 0,
    parameter int REFRESH  = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [CHANNELS*WIDTH-1:0] data_out,
    output logic [CHANNELS*WIDTH-1:0] data_in,
    output logic                      in_valid,
    output logic                      busy,
    output logic [FRAME_CNT_W-1:0]    frame_count,
    output logic                      SHIFT_CLK,
    output logic                      SHIFT_LOAD,
    output logic [CHANNELS-1:0]       SHIFT_OUT,
    input  logic [CHANNELS-1:0]       SHIFT_IN
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int REF_W = $clog2(REFRESH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH);
    localparam logic [REF_W-1:0] REF_MAX    = REF_W'(REFRESH);
    localparam logic [REF_W-1:0] REF_EXPIRE = REF_W'(REFRESH - 1);

    chain_state_t state;

    logic                      tick;
    logic                      start_frame;
    logic                      refresh_expired;
    logic [BIT_W-1:0]          bit_cnt;
    logic [REF_W-1:0]          refresh_cnt;
    logic [CHANNELS*WIDTH-1:0] tx_reg;
    logic [CHANNELS*WIDTH-1:0] rx_reg;
    logic [CHANNELS*WIDTH-1:0] last_sent;
    logic [CHANNELS*WIDTH-1:0] tx_shifted;
    logic [CHANNELS*WIDTH-1:0] rx_shifted;
    logic [CHANNELS-1:0]       tx_msb;

    expansion_tick_gen #(
        .DIVIDER (DIVIDER)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Per-channel views of the shift registers: current MSB and next shifted values.
    always_comb begin
        tx_msb     = '0;
        tx_shifted = '0;
        rx_shifted = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            tx_msb[c] = tx_reg[c*WIDTH + WIDTH - 1];
            tx_shifted[c*WIDTH +: WIDTH] = {tx_reg[c*WIDTH +: WIDTH-1], 1'b0};
            rx_shifted[c*WIDTH +: WIDTH] = {rx_reg[c*WIDTH +: WIDTH-1], SHIFT_IN[c]};
        end
    end

    // Decide whether an idle tick launches a frame; the refresh window counts the deciding tick.
    always_comb begin
        refresh_expired = (refresh_cnt >= REF_EXPIRE);
        if (ONCHANGE != 0) begin
            start_frame = enable && ((data_out != last_sent) || refresh_expired);
        end else begin
            start_frame = enable;
        end
    end

    // Refresh timer: counts idle ticks, saturates when expired, reloads when a frame starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= REF_MAX;
        end else if (tick && (state == IDLE)) begin
            if (start_frame) begin
                refresh_cnt <= '0;
            end else if (refresh_cnt != REF_MAX) begin
                refresh_cnt <= refresh_cnt + REF_W'(1);
            end
        end
    end

    // Frame sequencer with registered pin outputs, result capture and frame counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            SHIFT_CLK   <= 1'b0;
            SHIFT_LOAD  <= 1'b1;
            SHIFT_OUT   <= '0;
            data_in     <= '0;
            in_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            bit_cnt     <= '0;
            tx_reg      <= '0;
            rx_reg      <= '0;
            last_sent   <= '0;
        end else begin
            in_valid <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (start_frame) begin
                            state      <= LOAD;
                            SHIFT_LOAD <= 1'b0;
                            tx_reg     <= data_out;
                            last_sent  <= data_out;
                            busy       <= 1'b1;
                            bit_cnt    <= '0;
                        end
                    end
                    LOAD: begin
                        state      <= SHIFT_LO;
                        SHIFT_LOAD <= 1'b1;
                        SHIFT_CLK  <= 1'b0;
                        SHIFT_OUT  <= tx_msb;
                    end
                    SHIFT_LO: begin
                        state     <= SHIFT_HI;
                        SHIFT_CLK <= 1'b1;
                        tx_reg    <= tx_shifted;
                        rx_reg    <= rx_shifted;
                        bit_cnt   <= bit_cnt + BIT_W'(1);
                    end
                    SHIFT_HI: begin
                        SHIFT_CLK <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state       <= IDLE;
                            data_in     <= rx_reg;
                            in_valid    <= 1'b1;
                            frame_count <= frame_count + FRAME_CNT_W'(1);
                            busy        <= 1'b0;
                        end else begin
                            state     <= SHIFT_LO;
                            SHIFT_OUT <= tx_msb;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
